serial_load_sequencer: RTL and testbench
========================================

SERIAL_LOAD_SEQUENCER -- requirements
Module: serial_load_sequencer

Interface
REQ-001 Parameter: GAP_CYCLES, default 0, number of idle cycles inserted after each completed word before the next word is accepted (range 0..15).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET_B  input  1  reset, asynchronous, active-low.
REQ-004 IN_VALID  input  1  upstream word valid.
REQ-005 IN_READY  output  1  block can accept a word this cycle.
REQ-006 IN_DATA  input  4  parallel word to serialize.
REQ-007 ABORT  input  1  synchronous cancel of the word in progress.
REQ-008 LOAD  output  1  shift enable to the downstream 4-bit shift register.
REQ-009 DATA_IN  output  4  data to the downstream shift register; only bit 0 (serial bit) is meaningful.
REQ-010 WORD_DONE  output  1  one-cycle pulse; downstream register holds the complete word.
REQ-011 BUSY  output  1  high whenever state is not IDLE.
REQ-012 WORD_CNT  output  8  count of completed words.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, GAP.
REQ-014 IN_READY SHALL equal (RESET_B high) AND (state IDLE) AND (ABORT low), combinationally.
REQ-015 Accept SHALL occur on a rising edge with IN_VALID and IN_READY both high; IN_DATA is captured into an internal hold register, bit index set to 3, state goes to SHIFT.
REQ-016 IN_DATA SHALL be ignored except at accept; later changes to IN_DATA do not affect the word in progress.
REQ-017 LOAD, DATA_IN and WORD_DONE SHALL be registered outputs.
REQ-018 For accept at edge k, LOAD SHALL be high in exactly the four cycles following edges k..k+3, and low otherwise.
REQ-019 While LOAD is high, DATA_IN[0] SHALL be hold[3], hold[2], hold[1], hold[0] in successive cycles (MSB first), so the downstream register holds the full word, MSB in bit 3, after edge k+4.
REQ-020 DATA_IN[3:1] SHALL be 0 at all times; DATA_IN[0] SHALL be 0 whenever LOAD is low.
REQ-021 WORD_DONE SHALL be high for exactly one cycle, the cycle after the fourth LOAD cycle (i.e. after edge k+4).
REQ-022 WORD_CNT SHALL increment by 1 on the edge that asserts WORD_DONE, wrapping 255 -> 0.
REQ-023 After the fourth LOAD cycle, state SHALL go to GAP if GAP_CYCLES > 0 (staying GAP_CYCLES cycles) else directly to IDLE.
REQ-024 With GAP_CYCLES=0, IN_READY SHALL be high in the WORD_DONE cycle; minimum accept-to-accept spacing is 5 cycles (one LOAD-low cycle between words).
REQ-025 ABORT high on an edge in SHIFT or GAP SHALL force IDLE; LOAD and DATA_IN go 0 next cycle, no WORD_DONE, WORD_CNT unchanged.
REQ-026 ABORT high in IDLE SHALL block acceptance (IN_READY low) and have no other effect.
REQ-027 BUSY SHALL be high in SHIFT and GAP, low in IDLE.

Reset
REQ-028 RESET_B low SHALL immediately force state IDLE, hold register 0, bit index 3, gap counter 0.
REQ-029 During reset outputs SHALL be: LOAD=0, DATA_IN=4'b0000, WORD_DONE=0, BUSY=0, WORD_CNT=0, IN_READY=0.
REQ-030 Reset asserted mid-word SHALL discard the word with no WORD_DONE; first accept possible on the first rising edge with RESET_B high.

Verification
REQ-031 Single word: IN_DATA=4'b1011, IN_VALID one cycle, GAP_CYCLES=0 -> LOAD high 4 cycles with DATA_IN[0]=1,0,1,1; WORD_DONE next cycle; downstream DATA_OUT=4'b1011; WORD_CNT=1.
REQ-032 Back-to-back: IN_VALID held high with 4'b0110 then 4'b1001 -> accepts 5 cycles apart, one LOAD-low cycle between words, WORD_CNT=2.
REQ-033 Gap: GAP_CYCLES=3, IN_VALID held high -> IN_READY low for 3 cycles after WORD_DONE, accepts 8 cycles apart.
REQ-034 Abort: accept 4'b1111, ABORT high on the edge after the second LOAD cycle -> LOAD low next cycle, no WORD_DONE, WORD_CNT unchanged, IN_READY high again.
REQ-035 Reset mid-word: RESET_B low during third LOAD cycle -> all outputs at reset values immediately; after release, new word 4'b0001 serializes normally.
REQ-036 Wrap: 256 completed words -> WORD_CNT returns to 0 on the 256th WORD_DONE.

Source files
------------

// File: rtl/serial_load_sequencer.sv
// Serializes 4-bit words MSB first into a downstream shift register via LOAD/DATA_IN,
// with an optional idle gap after each completed word and a synchronous abort.
module serial_load_sequencer #(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic       CLK,
   input  logic       RESET_B,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [3:0] IN_DATA,
   input  logic       ABORT,
   output logic       LOAD,
   output logic [3:0] DATA_IN,
   output logic       WORD_DONE,
   output logic       BUSY,
   output logic [7:0] WORD_CNT
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Gap counter counts down to zero, so it is loaded with one less than the gap length.
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] gap_q, gap_d;
   logic       load_q, load_d;
   logic       bit_q, bit_d;
   logic       done_q, done_d;
   logic [7:0] cnt_q, cnt_d;
   logic       accept_s;
   logic [1:0] idx_nx_s;

   assign IN_READY = RESET_B && (state_q == ST_IDLE) && !ABORT;
   assign accept_s = IN_VALID && IN_READY;
   assign idx_nx_s = idx_q - 2'd1;

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      load_d  = 1'b0;
      bit_d   = 1'b0;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               hold_d  = IN_DATA;
               idx_d   = 2'd3;
               load_d  = 1'b1;
               bit_d   = IN_DATA[3];
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (ABORT) begin
               idx_d   = 2'd3;
               state_d = ST_IDLE;
            end else if (idx_q != 2'd0) begin
               idx_d  = idx_nx_s;
               load_d = 1'b1;
               bit_d  = hold_q[idx_nx_s];
            end else begin
               // idx 0 was presented last cycle: the downstream register is now full
               idx_d  = 2'd3;
               done_d = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               if (GAP_CYCLES > 0) begin
                  gap_d   = GAP_LAST;
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (ABORT || (gap_q == 4'd0)) begin
               gap_d   = 4'd0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q <= ST_IDLE;
         hold_q  <= 4'd0;
         idx_q   <= 2'd3;
         gap_q   <= 4'd0;
         load_q  <= 1'b0;
         bit_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         load_q  <= load_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign LOAD      = load_q;
   assign DATA_IN   = {3'b000, bit_q};
   assign WORD_DONE = done_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign WORD_CNT  = cnt_q;

endmodule

// File: tb/tb_serial_load_sequencer.sv
// Randomized bench for serial_load_sequencer: two instances (gap 0 and gap 3) share stimulus
// and are checked against a timeline model built on accept-edge arithmetic.
module tb_serial_load_sequencer;

   logic       CLK = 1'b0;
   logic       RESET_B;
   logic       IN_VALID;
   logic       ABORT;
   logic [3:0] IN_DATA;

   logic       in_ready_s [2];
   logic       load_s     [2];
   logic [3:0] data_in_s  [2];
   logic       done_s     [2];
   logic       busy_s     [2];
   logic [7:0] cnt_s      [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   serial_load_sequencer #(.GAP_CYCLES(0)) dut_g0 (
      .CLK(CLK), .RESET_B(RESET_B), .IN_VALID(IN_VALID), .IN_READY(in_ready_s[0]),
      .IN_DATA(IN_DATA), .ABORT(ABORT), .LOAD(load_s[0]), .DATA_IN(data_in_s[0]),
      .WORD_DONE(done_s[0]), .BUSY(busy_s[0]), .WORD_CNT(cnt_s[0])
   );

   serial_load_sequencer #(.GAP_CYCLES(3)) dut_g3 (
      .CLK(CLK), .RESET_B(RESET_B), .IN_VALID(IN_VALID), .IN_READY(in_ready_s[1]),
      .IN_DATA(IN_DATA), .ABORT(ABORT), .LOAD(load_s[1]), .DATA_IN(data_in_s[1]),
      .WORD_DONE(done_s[1]), .BUSY(busy_s[1]), .WORD_CNT(cnt_s[1])
   );

   // Downstream 4-bit shift registers fed by each instance
   logic [3:0] sr_q [2];
   always @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         sr_q[0] <= 4'd0;
         sr_q[1] <= 4'd0;
      end else begin
         if (load_s[0]) sr_q[0] <= {sr_q[0][2:0], data_in_s[0][0]};
         if (load_s[1]) sr_q[1] <= {sr_q[1][2:0], data_in_s[1][0]};
      end
   end

   // Model: a word accepted at edge s loads on edges s..s+3, completes at s+4, busy through s+3+gap
   bit         act_m   [2];
   int         s_m     [2];
   logic [3:0] w_m     [2];
   logic [7:0] cnt_m   [2];
   int         gap_m   [2] = '{0, 3};
   bit         pre_busy[2];
   bit         rdy_m   [2];
   int         e_n = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_reset_outputs();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("g%0d_rst_load", gap_m[i]), 32'(load_s[i]), 32'd0);
         check_eq($sformatf("g%0d_rst_data_in", gap_m[i]), 32'(data_in_s[i]), 32'd0);
         check_eq($sformatf("g%0d_rst_done", gap_m[i]), 32'(done_s[i]), 32'd0);
         check_eq($sformatf("g%0d_rst_busy", gap_m[i]), 32'(busy_s[i]), 32'd0);
         check_eq($sformatf("g%0d_rst_cnt", gap_m[i]), 32'(cnt_s[i]), 32'd0);
         check_eq($sformatf("g%0d_rst_ready", gap_m[i]), 32'(in_ready_s[i]), 32'd0);
      end
   endtask

   task automatic step(input bit v, input logic [3:0] d, input bit a);
      int   ph;
      bit   ld;
      bit   dn;
      bit   bz;
      logic b;
      @(negedge CLK);
      IN_VALID = v;
      IN_DATA  = d;
      ABORT    = a;
      #1;
      for (int i = 0; i < 2; i++) begin
         pre_busy[i] = act_m[i] && (e_n <= s_m[i] + 3 + gap_m[i]);
         rdy_m[i]    = RESET_B && !pre_busy[i] && !a;
         check_eq($sformatf("g%0d_in_ready", gap_m[i]), 32'(in_ready_s[i]), 32'(rdy_m[i]));
      end
      @(posedge CLK);
      #1;
      e_n++;
      for (int i = 0; i < 2; i++) begin
         if (!RESET_B) begin
            act_m[i] = 1'b0;
            cnt_m[i] = 8'd0;
         end else if (a && pre_busy[i]) begin
            act_m[i] = 1'b0;
         end else if (v && rdy_m[i]) begin
            act_m[i] = 1'b1;
            s_m[i]   = e_n;
            w_m[i]   = d;
         end
         ph = e_n - s_m[i];
         ld = act_m[i] && (ph >= 0) && (ph <= 3);
         b  = ld ? w_m[i][3 - ph] : 1'b0;
         dn = act_m[i] && (ph == 4);
         bz = act_m[i] && (ph <= 3 + gap_m[i]);
         if (dn) cnt_m[i] = cnt_m[i] + 8'd1;
         check_eq($sformatf("g%0d_load", gap_m[i]), 32'(load_s[i]), 32'(ld));
         check_eq($sformatf("g%0d_data_in", gap_m[i]), 32'(data_in_s[i]), {31'd0, b});
         check_eq($sformatf("g%0d_word_done", gap_m[i]), 32'(done_s[i]), 32'(dn));
         check_eq($sformatf("g%0d_busy", gap_m[i]), 32'(busy_s[i]), 32'(bz));
         check_eq($sformatf("g%0d_word_cnt", gap_m[i]), 32'(cnt_s[i]), 32'(cnt_m[i]));
         if (dn) check_eq($sformatf("g%0d_data_out", gap_m[i]), 32'(sr_q[i]), 32'(w_m[i]));
      end
   endtask

   task automatic reset_pulse();
      @(negedge CLK);
      #2;
      RESET_B = 1'b0;
      #1;
      check_reset_outputs();
      for (int i = 0; i < 2; i++) begin
         act_m[i] = 1'b0;
         cnt_m[i] = 8'd0;
      end
      step(1'b1, 4'b1010, 1'b0);
      RESET_B = 1'b1;
   endtask

   initial begin
      RESET_B  = 1'b0;
      IN_VALID = 1'b0;
      ABORT    = 1'b0;
      IN_DATA  = 4'd0;
      for (int i = 0; i < 2; i++) begin
         act_m[i] = 1'b0;
         s_m[i]   = 0;
         w_m[i]   = 4'd0;
         cnt_m[i] = 8'd0;
      end
      #3;
      check_reset_outputs();
      repeat (2) @(posedge CLK);
      #1;
      RESET_B = 1'b1;

      // single word 1011
      step(1'b1, 4'b1011, 1'b0);
      for (int n = 0; n < 8; n++) step(1'b0, 4'($urandom), 1'b0);

      // back-to-back with IN_VALID held; data switches after the first accept
      for (int n = 0; n < 5; n++) step(1'b1, 4'b0110, 1'b0);
      for (int n = 0; n < 11; n++) step(1'b1, 4'b1001, 1'b0);
      for (int n = 0; n < 8; n++) step(1'b0, 4'($urandom), 1'b0);

      // abort after the second LOAD cycle
      step(1'b1, 4'b1111, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b1);
      for (int n = 0; n < 6; n++) step(1'b0, 4'($urandom), 1'b0);

      // abort while idle blocks acceptance
      step(1'b1, 4'b0101, 1'b1);
      step(1'b0, 4'b0000, 1'b0);

      // reset during the third LOAD cycle, then a fresh word
      step(1'b1, 4'b1100, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      reset_pulse();
      step(1'b1, 4'b0001, 1'b0);
      for (int n = 0; n < 10; n++) step(1'b0, 4'($urandom), 1'b0);

      // random traffic, long enough for both word counters to wrap
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 9) != 0, 4'($urandom), $urandom_range(0, 63) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
